// File: rtl/knn_dist_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : knn_dist_pkg                                           |
// | Description : Shared entry type for the kNN distance pipeline and    |
// |               the downstream sorter/merger.                          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package knn_dist_pkg;

  localparam int KNN_BIT_WIDTH  = 16;
  localparam int KNN_ADDR_WIDTH = 16;
  localparam int KNN_DIST_WIDTH = 2*KNN_BIT_WIDTH + 2;

  // One neighbour candidate: coordinates, an opaque address tag, a valid
  // flag and the distance field that the pipeline fills in.
  typedef struct packed {
    logic                            valid;
    logic [KNN_ADDR_WIDTH-1:0]       addr;
    logic signed [KNN_BIT_WIDTH-1:0] x;
    logic signed [KNN_BIT_WIDTH-1:0] y;
    logic signed [KNN_BIT_WIDTH-1:0] z;
    logic [KNN_DIST_WIDTH-1:0]       distance;
  } knn_entry_t;

endpackage
`default_nettype wire

// File: rtl/knn_dist_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : knn_dist_pipe                                          |
// | Description : Computes squared-L2 or L1 distance from a query point  |
// |               to K neighbour entries, LANES per cycle, through a     |
// |               2-stage pipeline, and returns all K as one beat.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module knn_dist_pipe
  import knn_dist_pkg::*;
#(
  parameter int BIT_WIDTH  = KNN_BIT_WIDTH,
  parameter int K          = 8,
  parameter int LANES      = 4,
  parameter int DIST_WIDTH = KNN_DIST_WIDTH
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [BIT_WIDTH-1:0] qp_x,
  input  logic signed [BIT_WIDTH-1:0] qp_y,
  input  logic signed [BIT_WIDTH-1:0] qp_z,
  input  logic                        dist_mode,
  input  knn_entry_t [0:K-1]          knn_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output knn_entry_t [0:K-1]          knn_out,
  output logic                        busy
);

  localparam int NB     = K / LANES;
  localparam int BEAT_W = $clog2(NB + 1);
  localparam int IDX_W  = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_accept;
  logic                  w_issue;
  logic [BEAT_W-1:0]     r_beat;
  logic                  r_mode;
  logic [BIT_WIDTH-1:0]  r_qx;
  logic [BIT_WIDTH-1:0]  r_qy;
  logic [BIT_WIDTH-1:0]  r_qz;
  logic                  r_a_vld;
  logic                  r_a_last;
  logic [BEAT_W-1:0]     r_a_beat;
  logic                  r_b_last;
  knn_entry_t [0:K-1]    r_out;
  logic [DIST_WIDTH-1:0] w_dist  [LANES];
  logic [IDX_W-1:0]      w_b_idx [LANES];

  // |a - b| of two signed coordinates; one extra bit keeps the difference exact.
  function automatic logic [BIT_WIDTH-1:0] f_absdiff(input logic [BIT_WIDTH-1:0] a,
                                                     input logic [BIT_WIDTH-1:0] b);
    logic [BIT_WIDTH:0] d;
    logic [BIT_WIDTH:0] nd;
    d  = {a[BIT_WIDTH-1], a} - {b[BIT_WIDTH-1], b};
    nd = -d;
    return d[BIT_WIDTH] ? nd[BIT_WIDTH-1:0] : d[BIT_WIDTH-1:0];
  endfunction

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_issue  = (r_state == S_RUN) && (r_beat != BEAT_W'(NB));

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs; DONE is entered once the last beat
  // has left stage B.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (r_b_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request capture, beat counter and pipeline valid/last tracking.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_beat   <= '0;
      r_mode   <= 1'b0;
      r_qx     <= '0;
      r_qy     <= '0;
      r_qz     <= '0;
      r_a_vld  <= 1'b0;
      r_a_last <= 1'b0;
      r_a_beat <= '0;
      r_b_last <= 1'b0;
    end else begin
      r_a_vld  <= w_issue;
      r_b_last <= r_a_vld && r_a_last;
      if (w_accept) begin
        r_beat <= '0;
        r_mode <= dist_mode;
        r_qx   <= qp_x;
        r_qy   <= qp_y;
        r_qz   <= qp_z;
      end else if (w_issue) begin
        r_beat <= r_beat + 1'b1;
      end
      if (w_issue) begin
        r_a_beat <= r_beat;
        r_a_last <= (r_beat == BEAT_W'(NB - 1));
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [IDX_W-1:0]      w_a_idx;
    logic [BIT_WIDTH-1:0]  r_ax;
    logic [BIT_WIDTH-1:0]  r_ay;
    logic [BIT_WIDTH-1:0]  r_az;
    logic                  r_ev;
    logic [DIST_WIDTH-1:0] w_sq;
    logic [DIST_WIDTH-1:0] w_l1;

    assign w_a_idx = IDX_W'(int'(r_beat) * LANES + l);

    // Stage A: per-axis absolute differences for this lane's entry.
    always_ff @(posedge clock) begin
      if (reset) begin
        r_ax <= '0;
        r_ay <= '0;
        r_az <= '0;
        r_ev <= 1'b0;
      end else if (w_issue) begin
        r_ax <= f_absdiff(r_out[w_a_idx].x, r_qx);
        r_ay <= f_absdiff(r_out[w_a_idx].y, r_qy);
        r_az <= f_absdiff(r_out[w_a_idx].z, r_qz);
        r_ev <= r_out[w_a_idx].valid;
      end
    end

    // Squares of 16-bit magnitudes summed three times fit in 2*BW+2 bits.
    assign w_sq = DIST_WIDTH'(r_ax) * DIST_WIDTH'(r_ax)
                + DIST_WIDTH'(r_ay) * DIST_WIDTH'(r_ay)
                + DIST_WIDTH'(r_az) * DIST_WIDTH'(r_az);
    assign w_l1 = DIST_WIDTH'(r_ax) + DIST_WIDTH'(r_ay) + DIST_WIDTH'(r_az);

    // Invalid entries read as "infinitely far" so the sorter drops them.
    assign w_dist[l]  = !r_ev ? '1 : (r_mode ? w_l1 : w_sq);
    assign w_b_idx[l] = IDX_W'(int'(r_a_beat) * LANES + l);
  end

  // Result buffer: loaded with the request on accept, stage B fills distances.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_out <= '0;
    end else if (w_accept) begin
      r_out <= knn_in;
      for (int k = 0; k < K; k++) r_out[k].distance <= '0;
    end else if (r_a_vld) begin
      for (int l = 0; l < LANES; l++) r_out[w_b_idx[l]].distance <= w_dist[l];
    end
  end

  assign knn_out = r_out;

endmodule
`default_nettype wire

// File: tb/tb_knn_dist_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_knn_dist_pipe                                       |
// | Description : Directed self-checking bench for knn_dist_pipe.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_knn_dist_pipe;
  import knn_dist_pkg::*;

  localparam int K     = 8;
  localparam int LANES = 4;
  localparam int DW    = 34;

  logic               clock = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] qp_x, qp_y, qp_z;
  logic               dist_mode;
  knn_entry_t [0:K-1] knn_in;
  logic               out_valid;
  logic               out_ready;
  knn_entry_t [0:K-1] knn_out;
  logic               busy;

  int checks = 0;
  int errors = 0;

  knn_entry_t [0:K-1] ents;
  logic signed [15:0] cqx, cqy, cqz;
  logic               cmode;

  always #5 clock = ~clock;

  knn_dist_pipe #(.BIT_WIDTH(16), .K(K), .LANES(LANES), .DIST_WIDTH(DW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .qp_x(qp_x), .qp_y(qp_y), .qp_z(qp_z), .dist_mode(dist_mode),
    .knn_in(knn_in), .out_valid(out_valid), .out_ready(out_ready),
    .knn_out(knn_out), .busy(busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference distance from plain integer arithmetic.
  function automatic logic [DW-1:0] model_dist(input knn_entry_t e, input logic m);
    longint dx, dy, dz;
    if (!e.valid) return '1;
    dx = longint'($signed(e.x)) - longint'(cqx); if (dx < 0) dx = -dx;
    dy = longint'($signed(e.y)) - longint'(cqy); if (dy < 0) dy = -dy;
    dz = longint'($signed(e.z)) - longint'(cqz); if (dz < 0) dz = -dz;
    if (m) return DW'(dx + dy + dz);
    return DW'(dx*dx + dy*dy + dz*dz);
  endfunction

  task automatic fill_random();
    for (int k = 0; k < K; k++) begin
      ents[k].valid    = 1'b1;
      ents[k].addr     = 16'($urandom);
      ents[k].x        = 16'($urandom);
      ents[k].y        = 16'($urandom);
      ents[k].z        = 16'($urandom);
      ents[k].distance = 34'($urandom);
    end
  endtask

  // Presents one request; returns #1 after the accepting edge.
  task automatic send(input logic m);
    @(negedge clock);
    chk("in_ready_idle", in_ready, 1'b1);
    in_valid  = 1'b1;
    qp_x = cqx; qp_y = cqy; qp_z = cqz;
    dist_mode = m;
    cmode     = m;
    knn_in    = ents;
    @(posedge clock); #1;
    in_valid = 1'b0;
    qp_x = ~cqx; qp_y = ~cqy; qp_z = ~cqz;
    knn_in = ~ents;
  endtask

  task automatic wait_result(input string tag);
    int lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    chk(tag, lat, 4);
  endtask

  task automatic check_out(input string tag);
    knn_entry_t e;
    for (int k = 0; k < K; k++) begin
      e = ents[k];
      e.distance = model_dist(ents[k], cmode);
      chk($sformatf("%s_e%0d", tag, k), knn_out[k], e);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk("rel_out_valid", out_valid, 1'b0);
    chk("rel_in_ready", in_ready, 1'b1);
    chk("rel_busy", busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dist_mode = 1'b0;
    qp_x = '0; qp_y = '0; qp_z = '0; knn_in = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    for (int k = 0; k < K; k++) chk($sformatf("rst_knn_e%0d", k), knn_out[k], '0);

    // Basic L2
    fill_random();
    cqx = 0; cqy = 0; cqz = 0;
    ents[0].x = 3; ents[0].y = 4; ents[0].z = 12; ents[0].addr = 16'h00A5;
    send(1'b0);
    chk("run_busy", busy, 1'b1);
    chk("run_in_ready", in_ready, 1'b0);
    wait_result("basic_lat");
    chk("basic_d0", knn_out[0].distance, 34'd169);
    chk("basic_addr0", knn_out[0].addr, 16'h00A5);
    check_out("basic");
    release_out();

    // Sign handling, L2 then L1 with a mode toggle during RUN
    fill_random();
    cqx = -5; cqy = 2; cqz = 0;
    ents[0].x = 5; ents[0].y = -2; ents[0].z = 0;
    send(1'b0);
    wait_result("sign_l2_lat");
    chk("sign_l2_d0", knn_out[0].distance, 34'd116);
    check_out("sign_l2");
    release_out();
    send(1'b1);
    dist_mode = 1'b0;
    wait_result("sign_l1_lat");
    chk("sign_l1_d0", knn_out[0].distance, 34'd14);
    check_out("sign_l1");
    release_out();

    // Extremes
    fill_random();
    cqx = -32768; cqy = 100; cqz = -7;
    ents[0].x = 32767; ents[0].y = 100; ents[0].z = -7;
    ents[1].x = 32767; ents[1].y = -32768; ents[1].z = 32767;
    send(1'b0);
    wait_result("ext_l2_lat");
    chk("ext_l2_d0", knn_out[0].distance, 34'd4294836225);
    check_out("ext_l2");
    release_out();
    out_ready = 1'b1;               // held high outside DONE: no effect
    send(1'b1);
    wait_result("ext_l1_lat");
    chk("ext_l1_d0", knn_out[0].distance, 34'd65535);
    check_out("ext_l1");
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk("ext_l1_drop", out_valid, 1'b0);

    // Invalid entries plus backpressure
    fill_random();
    cqx = 16'sd1234; cqy = -16'sd999; cqz = 16'sd42;
    ents[3].valid = 1'b0;
    ents[6].valid = 1'b0;
    send(1'b0);
    wait_result("inv_lat");
    chk("inv_d3", knn_out[3].distance, 34'h3_FFFF_FFFF);
    chk("inv_d6", knn_out[6].distance, 34'h3_FFFF_FFFF);
    chk("inv_v3", knn_out[3].valid, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      chk($sformatf("bp_out_valid_c%0d", c), out_valid, 1'b1);
      chk($sformatf("bp_in_ready_c%0d", c), in_ready, 1'b0);
      check_out($sformatf("bp_c%0d", c));
    end
    release_out();

    // Back-to-back request right after release
    fill_random();
    cqx = -16'sd300; cqy = 16'sd17; cqz = 16'sd20000;
    send(1'b1);
    wait_result("b2b_lat");
    check_out("b2b");
    release_out();

    // Reset during RUN
    fill_random();
    cqx = 1; cqy = 2; cqz = 3;
    send(1'b0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("mrst_out_valid", out_valid, 1'b0);
    chk("mrst_in_ready", in_ready, 1'b1);
    chk("mrst_busy", busy, 1'b0);
    for (int k = 0; k < K; k++) chk($sformatf("mrst_knn_e%0d", k), knn_out[k], '0);
    for (int c = 0; c < 8; c++) begin
      @(posedge clock); #1;
      chk($sformatf("mrst_no_stale_c%0d", c), out_valid, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
